// File: rtl/jpeg_punch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_punch_pkg
// Description : Shared types, constants and helpers for the punch generator.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_punch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        BURST = 3'd2,
        GAP   = 3'd3,
        TRAIL = 3'd4,
        DONE  = 3'd5
    } punch_state_t;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'd0,
        MODE_INC   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } punch_mode_t;

    // Right-shift Galois tap mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : jpeg_punch_pkg
`default_nettype wire

// File: rtl/punch_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : punch_lfsr
// Description : 32-bit Galois LFSR with advance enable. Exposes the value the
//               register will hold after this edge so the caller can load an
//               output register with the post-advance pattern in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module punch_lfsr
    import jpeg_punch_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        advance,
    output logic [31:0] state_next
);

    logic [31:0] state;

    assign state_next = advance ? lfsr_step(state) : state;

    // LFSR register, reseeded only by reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

endmodule : punch_lfsr
`default_nettype wire

// File: rtl/data_punch_gen.sv
`default_nettype none
// ============================================================================
// Module      : data_punch_gen
// Description : Frame generator: N_BURSTS bursts of BURST_LEN beats separated
//               by GAP_LEN idle cycles, optional trailing fill beats, then a
//               one-cycle end-of-frame pulse. Ready backpressure and status
//               counters. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module data_punch_gen
    import jpeg_punch_pkg::*;
#(
    parameter int             DW         = 8,
    parameter int             BURST_LEN  = 1024,
    parameter int             N_BURSTS   = 3,
    parameter int             GAP_LEN    = 6,
    parameter int             PRE_LEN    = 2,
    parameter int             TRAIL_W    = 10,
    parameter logic [DW-1:0]  TRAIL_FILL = {DW/8{8'hFF}},
    parameter logic [31:0]    LFSR_SEED  = 32'h1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [DW-1:0]      fill_i,
    input  logic [TRAIL_W-1:0] trailings_i,
    input  logic               data_ready_i,
    output logic               data_valid,
    output logic [DW-1:0]      data_out,
    output logic               data_frame_ready,
    output logic               busy_o,
    output logic [15:0]        frame_cnt_o,
    output logic [31:0]        byte_cnt_o
);

    localparam int CNT_W = imax(imax($clog2(BURST_LEN + 1), TRAIL_W),
                                imax($clog2(PRE_LEN + 2), $clog2(GAP_LEN + 2)));
    localparam int BC_W  = imax($clog2(N_BURSTS + 1), 1);

    punch_state_t       state_q, state_d, after_gap;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BC_W-1:0]    burst_q, burst_d, burst_inc;
    logic               more_bursts;

    punch_mode_t        mode_q;
    logic [DW-1:0]      fill_q;
    logic [TRAIL_W-1:0] trail_q;
    logic [DW-1:0]      inc_q, inc_d;
    logic [31:0]        byte_cnt_q;

    logic               accept, burst_accept, start_take, lfsr_adv;
    logic [31:0]        lfsr_next;
    logic [DW-1:0]      lfsr_word, pattern;
    logic               unused_lfsr_bits;

    assign accept       = data_valid && data_ready_i;
    assign burst_accept = accept && (state_q == BURST);
    assign start_take   = (state_q == IDLE) && start_i;
    assign lfsr_adv     = burst_accept && ((mode_q == MODE_LFSR) || (mode_q == MODE_RSVD));
    assign byte_cnt_o   = byte_cnt_q;

    punch_lfsr #(
        .SEED       (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rstn       (rstn),
        .advance    (lfsr_adv),
        .state_next (lfsr_next)
    );

    // Wide data words replicate the 32-bit LFSR; narrow ones take its low bits
    for (genvar gi = 0; gi < DW; gi++) begin : g_lfsr_rep
        assign lfsr_word[gi] = lfsr_next[gi % 32];
    end
    assign unused_lfsr_bits = ^lfsr_next;

    // Pattern value for the beat presented after this edge
    always_comb begin
        inc_d = inc_q;
        if (start_take) begin
            inc_d = '0;
        end else if (burst_accept) begin
            inc_d = inc_q + DW'(1);
        end
        case (mode_q)
            MODE_INC:   pattern = inc_d;
            MODE_CONST: pattern = fill_q;
            default:    pattern = lfsr_word;
        endcase
    end

    // Next-state logic; the burst counter is bumped as each burst completes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        burst_inc   = burst_q + BC_W'(1);
        more_bursts = (state_q == BURST) ? (burst_inc < BC_W'(N_BURSTS))
                                         : (burst_q < BC_W'(N_BURSTS));
        after_gap   = more_bursts ? BURST : ((trail_q != '0) ? TRAIL : DONE);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    burst_d = '0;
                end
            end
            // PRE always spends one extra cycle so the first beat can be
            // computed from the freshly latched mode/fill
            PRE: begin
                if (cnt_q == CNT_W'(PRE_LEN)) begin
                    state_d = BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BURST: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        cnt_d   = '0;
                        burst_d = burst_inc;
                        state_d = (GAP_LEN > 0) ? GAP : after_gap;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = after_gap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TRAIL: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(trail_q - TRAIL_W'(1))) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and frame parameters latched at start
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            burst_q <= '0;
            mode_q  <= MODE_LFSR;
            fill_q  <= '0;
            trail_q <= '0;
            inc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            inc_q   <= inc_d;
            if (start_take) begin
                mode_q  <= punch_mode_t'(mode_i);
                fill_q  <= fill_i;
                trail_q <= trailings_i;
            end
        end
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_valid       <= 1'b0;
            data_out         <= '0;
            data_frame_ready <= 1'b0;
            busy_o           <= 1'b0;
            frame_cnt_o      <= '0;
            byte_cnt_q       <= '0;
        end else begin
            data_valid       <= (state_d == BURST) || (state_d == TRAIL);
            data_out         <= (state_d == BURST) ? pattern :
                                (state_d == TRAIL) ? TRAIL_FILL : '0;
            data_frame_ready <= (state_d == DONE);
            busy_o           <= (state_d != IDLE);
            if (state_d == DONE) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 32'd1;
            end
        end
    end

endmodule : data_punch_gen
`default_nettype wire

// File: tb/tb_data_punch_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_punch_gen
// Description : Self-checking bench for data_punch_gen (DW=8 and DW=16 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_punch_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fill = 16'h0;
    logic [9:0]  trail = 10'd0;
    logic        ready = 1'b1;

    logic        v8, fr8, busy8, v16, fr16, busy16;
    logic [7:0]  d8;
    logic [15:0] d16, fc8, fc16;
    logic [31:0] bc8, bc16;

    logic        v_m, fr_m, busy_m;
    logic [15:0] d_m, fc_m;
    logic [31:0] bc_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_punch_gen #(
        .DW(8), .BURST_LEN(4), .N_BURSTS(2), .GAP_LEN(2), .PRE_LEN(2), .TRAIL_W(10)
    ) dut8 (
        .clk(clk), .rstn(rstn), .start_i(start & ~sel), .mode_i(mode), .fill_i(fill[7:0]),
        .trailings_i(trail), .data_ready_i(ready), .data_valid(v8), .data_out(d8),
        .data_frame_ready(fr8), .busy_o(busy8), .frame_cnt_o(fc8), .byte_cnt_o(bc8)
    );

    data_punch_gen #(
        .DW(16), .BURST_LEN(4), .N_BURSTS(2), .GAP_LEN(2), .PRE_LEN(2), .TRAIL_W(10)
    ) dut16 (
        .clk(clk), .rstn(rstn), .start_i(start & sel), .mode_i(mode), .fill_i(fill),
        .trailings_i(trail), .data_ready_i(ready), .data_valid(v16), .data_out(d16),
        .data_frame_ready(fr16), .busy_o(busy16), .frame_cnt_o(fc16), .byte_cnt_o(bc16)
    );

    assign v_m    = sel ? v16 : v8;
    assign d_m    = sel ? d16 : {8'h00, d8};
    assign fr_m   = sel ? fr16 : fr8;
    assign busy_m = sel ? busy16 : busy8;
    assign fc_m   = sel ? fc16 : fc8;
    assign bc_m   = sel ? bc16 : bc8;

    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       fill;
        logic [9:0]        trail;
        logic              toggle;
        logic [7:0]        nb;
        logic [7:0]        lag;
        logic [10:0][15:0] exp;
    } frame_vec_t;

    frame_vec_t vecs [0:6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic frame_vec_t mk(input logic [1:0] m, input logic [15:0] f,
                                      input logic [9:0] t, input logic tg,
                                      input logic [7:0] nb, input logic [7:0] lag);
        frame_vec_t v;
        v = '0;
        v.mode = m; v.fill = f; v.trail = t; v.toggle = tg; v.nb = nb; v.lag = lag;
        return v;
    endfunction

    // Run one frame from the current negedge and compare against vecs[idx]
    task automatic apply(input int idx, input logic [31:0] exp_bc, input logic [15:0] exp_fc);
        frame_vec_t  v;
        int          frs, first_v, last_acc, fr_cyc, ncap;
        logic        stall_prev;
        logic [15:0] d_prev;
        logic [15:0] cap [0:15];
        logic [31:0] got;
        v = vecs[idx];
        mode = v.mode; fill = v.fill; trail = v.trail; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frs = 0; first_v = -1; last_acc = -1; fr_cyc = -1; ncap = 0;
        stall_prev = 1'b0; d_prev = '0;
        for (int cyc = 0; cyc < 200 && frs == 0; cyc++) begin
            if (stall_prev) begin
                check($sformatf("v%0d hold valid c%0d", idx, cyc), {31'b0, v_m}, 32'd1);
                check($sformatf("v%0d hold data c%0d", idx, cyc), {16'b0, d_m}, {16'b0, d_prev});
            end
            if (v.toggle) ready = ~ready;
            if (fr_m) begin
                frs = 1;
                fr_cyc = cyc;
            end else begin
                if (v_m && first_v < 0) first_v = cyc;
                if (v_m && ready) begin
                    if (ncap < 16) cap[ncap] = d_m;
                    ncap++;
                    last_acc = cyc;
                end
                stall_prev = v_m && !ready;
                d_prev = d_m;
                @(negedge clk);
            end
        end
        check($sformatf("v%0d frame_ready seen", idx), frs, 1);
        check($sformatf("v%0d first beat cycle", idx), first_v, 3);
        check($sformatf("v%0d beat count", idx), ncap, {24'b0, v.nb});
        for (int i = 0; i < int'(v.nb); i++) begin
            got = (i < ncap && i < 16) ? {16'b0, cap[i]} : 32'hFFFF_FFFF;
            check($sformatf("v%0d beat %0d", idx, i), got, {16'b0, v.exp[i]});
        end
        check($sformatf("v%0d frame_ready lag", idx), fr_cyc - last_acc, {24'b0, v.lag});
        check($sformatf("v%0d byte_cnt", idx), bc_m, exp_bc);
        check($sformatf("v%0d frame_cnt", idx), {16'b0, fc_m}, {16'b0, exp_fc});
        ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d pulse width", idx), {31'b0, fr_m}, 32'd0);
        check($sformatf("v%0d busy after", idx), {31'b0, busy_m}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, {31'b0, v_m}, 32'd0);
        check({tag, " data"}, {16'b0, d_m}, 32'd0);
        check({tag, " frame_ready"}, {31'b0, fr_m}, 32'd0);
        check({tag, " busy"}, {31'b0, busy_m}, 32'd0);
        check({tag, " frame_cnt"}, {16'b0, fc_m}, 32'd0);
        check({tag, " byte_cnt"}, bc_m, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int frs, idles, nb;
        int fr_at [0:2];
        bit seen;
        logic [15:0] fc_base;
        logic [31:0] bc_base;

        // Stimulus table
        vecs[0] = mk(2'd1, 16'h00, 10'd3, 1'b0, 8'd11, 8'd1);   // INC, trail 3
        vecs[1] = mk(2'd1, 16'h00, 10'd3, 1'b1, 8'd11, 8'd1);   // INC, ready toggling
        for (int i = 0; i < 8; i++) begin
            vecs[0].exp[i] = 16'(i);
            vecs[1].exp[i] = 16'(i);
        end
        for (int i = 8; i < 11; i++) begin
            vecs[0].exp[i] = 16'h00FF;
            vecs[1].exp[i] = 16'h00FF;
        end
        vecs[2] = mk(2'd2, 16'hA5, 10'd0, 1'b0, 8'd8, 8'd3);    // CONST, no trail
        vecs[3] = mk(2'd2, 16'h3C, 10'd2, 1'b1, 8'd10, 8'd1);   // CONST, toggling
        for (int i = 0; i < 8; i++) begin
            vecs[2].exp[i] = 16'h00A5;
            vecs[3].exp[i] = 16'h003C;
        end
        vecs[3].exp[8] = 16'h00FF;
        vecs[3].exp[9] = 16'h00FF;
        vecs[4] = mk(2'd0, 16'h00, 10'd0, 1'b0, 8'd8, 8'd3);    // LFSR after reset
        vecs[4].exp[7:0] = {16'h03, 16'h01, 16'h02, 16'h03, 16'h01, 16'h02, 16'h03, 16'h01};
        vecs[5] = mk(2'd0, 16'h00, 10'd1, 1'b0, 8'd9, 8'd1);    // DW16 LFSR frame 1
        vecs[5].exp[8:0] = {16'hFFFF, 16'h8003, 16'h0001, 16'h0002, 16'h0003,
                            16'h0001, 16'h0002, 16'h0003, 16'h0001};
        vecs[6] = mk(2'd3, 16'h00, 10'd1, 1'b1, 8'd9, 8'd1);    // DW16 reserved=LFSR, frame 2
        vecs[6].exp[8:0] = {16'hFFFF, 16'h6D81, 16'hDB02, 16'hB603, 16'h6C01,
                            16'hD802, 16'hB003, 16'h6001, 16'hC002};

        // Reset state of both instances
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0; #1; check_zero("reset dw8");
        sel = 1'b1; #1; check_zero("reset dw16");
        sel = 1'b0;
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven frames on the 8-bit instance
        apply(0, 32'd11, 16'd1);
        apply(1, 32'd22, 16'd2);
        apply(2, 32'd30, 16'd3);
        apply(3, 32'd40, 16'd4);

        // start held high: three frames with one idle cycle between them
        fc_base = fc_m; bc_base = bc_m;
        mode = 2'd1; trail = 10'd3; ready = 1'b1; start = 1'b1;
        frs = 0; idles = 0; seen = 1'b0;
        for (int c = 0; c < 200 && frs < 3; c++) begin
            @(negedge clk);
            if (busy_m) seen = 1'b1;
            else if (seen) idles++;
            if (fr_m) begin
                fr_at[frs] = c;
                frs++;
                if (frs == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held start frames", frs, 3);
        check("held start idle gaps", idles, 2);
        check("held start period 1", fr_at[1] - fr_at[0], 20);
        check("held start period 2", fr_at[2] - fr_at[1], 20);
        repeat (30) @(negedge clk);
        check("held start frame_cnt", {16'b0, fc_m - fc_base}, 32'd3);
        check("held start byte_cnt", bc_m - bc_base, 32'd33);
        check("held start idle after", {31'b0, busy_m}, 32'd0);

        // Reset in the middle of a burst
        mode = 2'd0; trail = 10'd0; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            if (v_m) nb++;
            if (nb < 2) @(negedge clk);
        end
        check("mid-burst beats before reset", nb, 2);
        rstn = 1'b0;
        @(negedge clk);
        check_zero("mid-burst reset");
        rstn = 1'b1;
        @(negedge clk);
        apply(4, 32'd8, 16'd1);

        // 16-bit instance: LFSR continues across frames, byte counter wraps
        sel = 1'b1;
        @(negedge clk);
        apply(5, 32'd9, 16'd1);
        force dut16.byte_cnt_q = 32'hFFFF_FFFC;
        @(negedge clk);
        release dut16.byte_cnt_q;
        @(negedge clk);
        check("dw16 preset byte_cnt", bc_m, 32'hFFFF_FFFC);
        apply(6, 32'd5, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_punch_gen
`default_nettype wire
